// File: rtl/alu_pkg.sv
// Shared ALU operation codes and the sequencer's state/operation types.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_LSL = 5'b10000;
  localparam logic [4:0] OP_LSR = 5'b10001;

  typedef enum logic [2:0] {
    IDLE,
    MUL_ADD,
    MUL_SHL,
    DIV_SHL,
    DIV_SUB,
    DONE
  } seq_state_t;

  typedef enum logic {
    MUL = 1'b0,
    DIV = 1'b1
  } seq_op_t;

endpackage

// File: rtl/alu_bus_mux.sv
// Selects who drives the shared ALU: the core when idle, the sequencer while busy.
module alu_bus_mux
  import alu_pkg::*;
(
  input  logic              sel_seq_i,
  input  logic [4:0]        core_op_i,
  input  logic [DATA_W-1:0] core_a_i,
  input  logic [DATA_W-1:0] core_b_i,
  input  logic [4:0]        seq_op_i,
  input  logic [DATA_W-1:0] seq_a_i,
  input  logic [DATA_W-1:0] seq_b_i,
  output logic [4:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o
);

  assign alu_op_o = sel_seq_i ? seq_op_i : core_op_i;
  assign alu_a_o  = sel_seq_i ? seq_a_i  : core_a_i;
  assign alu_b_o  = sel_seq_i ? seq_b_i  : core_b_i;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle MUL (low byte) / restoring DIV sequencer borrowing the shared ALU.
// Optional macro ALU_SEQ_EARLY_EXIT_EN: MUL finishes once remaining multiplier bits are zero.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int ITER = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              seq_op,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic [4:0]        core_op,
  input  logic [DATA_W-1:0] core_a,
  input  logic [DATA_W-1:0] core_b,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_less,
  output logic              busy,
  output logic              core_stall,
  output logic              done,
  output logic [DATA_W-1:0] res_lo,
  output logic [DATA_W-1:0] res_hi,
  output logic              div_err
);

  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [IW-1:0] LAST = IW'(ITER - 1);

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dividend_q, dividend_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [IW-1:0]     i_q, i_d;
  logic [DATA_W-1:0] res_lo_q, res_lo_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d;
  logic              div_err_q, div_err_d;

  logic [4:0]        seq_alu_op;
  logic [DATA_W-1:0] seq_alu_a;
  logic [DATA_W-1:0] seq_alu_b;
  logic              mul_last;

`ifdef ALU_SEQ_EARLY_EXIT_EN
  assign mul_last = (i_q == LAST) || (((mplier_q >> i_q) >> 1) == '0);
`else
  assign mul_last = (i_q == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      i_q        <= '0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      i_q        <= i_d;
      res_lo_q   <= res_lo_d;
      res_hi_q   <= res_hi_d;
      div_err_q  <= div_err_d;
    end
  end

  // Results are loaded on the transition into DONE so they are valid while done is high.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    i_d        = i_q;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    div_err_d  = div_err_q;
    seq_alu_op = OP_AND;
    seq_alu_a  = '0;
    seq_alu_b  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d    = opA;
          mplier_d   = opB;
          dividend_d = opA;
          divisor_d  = opB;
          acc_d      = '0;
          rem_d      = '0;
          quot_d     = '0;
          div_err_d  = 1'b0;
          if (seq_op_t'(seq_op) == DIV) begin
            i_d     = LAST;
            state_d = DIV_SHL;
          end else begin
            i_d     = '0;
            state_d = MUL_ADD;
          end
        end
      end

      MUL_ADD: begin
        seq_alu_op = OP_ADD;
        seq_alu_a  = acc_q;
        seq_alu_b  = mcand_q;
        if (mplier_q[i_q]) acc_d = alu_result;
        state_d = MUL_SHL;
      end

      MUL_SHL: begin
        seq_alu_op = OP_LSL;
        seq_alu_a  = mcand_q;
        seq_alu_b  = DATA_W'(1);
        mcand_d    = alu_result;
        if (mul_last) begin
          res_lo_d  = acc_q;
          res_hi_d  = '0;
          state_d   = DONE;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = MUL_ADD;
        end
      end

      // A zero divisor spends its first busy cycle here, then reports the error.
      DIV_SHL: begin
        if (divisor_q == '0) begin
          res_lo_d  = 8'hFF;
          res_hi_d  = dividend_q;
          div_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          seq_alu_op = OP_LSL;
          seq_alu_a  = rem_q;
          seq_alu_b  = DATA_W'(1);
          rem_d      = alu_result | {{(DATA_W-1){1'b0}}, dividend_q[i_q]};
          state_d    = DIV_SUB;
        end
      end

      DIV_SUB: begin
        seq_alu_op = OP_SUB;
        seq_alu_a  = rem_q;
        seq_alu_b  = divisor_q;
        if (!alu_less) begin
          rem_d       = alu_result;
          quot_d[i_q] = 1'b1;
        end else begin
          quot_d[i_q] = 1'b0;
        end
        if (i_q == '0) begin
          res_lo_d = quot_d;
          res_hi_d = rem_d;
          state_d  = DONE;
        end else begin
          i_d     = i_q - IW'(1);
          state_d = DIV_SHL;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign core_stall = busy;
  assign done       = (state_q == DONE);
  assign res_lo     = res_lo_q;
  assign res_hi     = res_hi_q;
  assign div_err    = div_err_q;

  alu_bus_mux u_bus_mux (
    .sel_seq_i (busy),
    .core_op_i (core_op),
    .core_a_i  (core_a),
    .core_b_i  (core_b),
    .seq_op_i  (seq_alu_op),
    .seq_a_i   (seq_alu_a),
    .seq_b_i   (seq_alu_b),
    .alu_op_o  (alu_op),
    .alu_a_o   (alu_a),
    .alu_b_o   (alu_b)
  );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural combinational ALU.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       seq_op = 1'b0;
  logic [7:0] opA = '0, opB = '0;
  logic [4:0] core_op = '0;
  logic [7:0] core_a = '0, core_b = '0;
  logic [4:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_less;
  logic       busy, core_stall, done, div_err;
  logic [7:0] res_lo, res_hi;

  int testsRun = 0;
  int testsFailed = 0;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seq_op(seq_op),
    .opA(opA), .opB(opB), .core_op(core_op), .core_a(core_a), .core_b(core_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_less(alu_less),
    .busy(busy), .core_stall(core_stall), .done(done),
    .res_lo(res_lo), .res_hi(res_hi), .div_err(div_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU: purely combinational, unsigned compare for less.
  always_comb begin
    alu_result = 8'h00;
    alu_less   = (alu_a < alu_b);
    case (alu_op)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_LSL:  alu_result = alu_a << alu_b;
      OP_LSR:  alu_result = alu_a >> alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  // Drives one sequence; returns at the negedge of the done cycle (or after a timeout).
  task automatic run_seq(input logic op, input logic [7:0] a, input logic [7:0] b,
                         output int doneCyc, output int stallCnt, output logic stallAtDone,
                         output logic [4:0] op1, output logic [7:0] a1, output logic [7:0] b1);
    @(negedge clk);
    start = 1'b1; seq_op = op; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0;
    doneCyc = -1; stallCnt = 0; stallAtDone = 1'b1;
    op1 = '0; a1 = '0; b1 = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) begin op1 = alu_op; a1 = alu_a; b1 = alu_b; end
      if (core_stall) stallCnt++;
      if (done) begin doneCyc = c; stallAtDone = core_stall; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    core_op = OP_ADD; core_a = 8'd7; core_b = 8'd9;
    repeat (2) @(negedge clk);
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %0b, expected 0", done); end
    testsRun++; if (res_lo !== 8'd0 || res_hi !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_res: got %0d/%0d, expected 0/0", res_lo, res_hi); end
    testsRun++; if (div_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_div_err: got %0b, expected 0", div_err); end
    testsRun++; if (alu_op !== OP_ADD || alu_a !== 8'd7) begin testsFailed++; $display("[TB] FAIL reset_bus: got op %0h a %0d, expected op 4 a 7", alu_op, alu_a); end
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    core_op = OP_ADD; core_a = 8'd3; core_b = 8'd4;
    #1;
    testsRun++; if (alu_op !== 5'b00100) begin testsFailed++; $display("[TB] FAIL pass_op: got %b, expected 00100", alu_op); end
    testsRun++; if (alu_a !== 8'd3 || alu_b !== 8'd4) begin testsFailed++; $display("[TB] FAIL pass_ab: got %0d/%0d, expected 3/4", alu_a, alu_b); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL pass_busy: got %0b, expected 0", busy); end
  endtask

  task automatic test_mul;
    int dc, sc; logic sd; logic [4:0] o1; logic [7:0] x1, y1;
    core_op = OP_AND; core_a = 8'hAA; core_b = 8'h55;
    run_seq(1'b0, 8'd13, 8'd11, dc, sc, sd, o1, x1, y1);
    testsRun++; if (dc !== 17) begin testsFailed++; $display("[TB] FAIL mul13x11_latency: got cycle %0d, expected 17", dc); end
    testsRun++; if (res_lo !== 8'd143 || res_hi !== 8'd0) begin testsFailed++; $display("[TB] FAIL mul13x11_res: got %0d/%0d, expected 143/0", res_lo, res_hi); end
    testsRun++; if (sc !== 16 || sd !== 1'b0) begin testsFailed++; $display("[TB] FAIL mul13x11_stall: got %0d cycles (at done %0b), expected 16 (0)", sc, sd); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mul13x11_busy_at_done: got %0b, expected 0", busy); end
    testsRun++; if (o1 !== OP_ADD || x1 !== 8'd0 || y1 !== 8'd13) begin testsFailed++; $display("[TB] FAIL mul_first_alu: got op %0h a %0d b %0d, expected op 4 a 0 b 13", o1, x1, y1); end
    run_seq(1'b0, 8'd20, 8'd20, dc, sc, sd, o1, x1, y1);
    testsRun++; if (dc !== 17) begin testsFailed++; $display("[TB] FAIL mul20x20_latency: got cycle %0d, expected 17", dc); end
    testsRun++; if (res_lo !== 8'h90 || res_hi !== 8'd0) begin testsFailed++; $display("[TB] FAIL mul20x20_res: got %0h/%0h, expected 90/0", res_lo, res_hi); end
  endtask

  task automatic test_div_zero;
    int dc, sc; logic sd; logic [4:0] o1; logic [7:0] x1, y1;
    run_seq(1'b1, 8'd9, 8'd0, dc, sc, sd, o1, x1, y1);
    testsRun++; if (dc !== 2) begin testsFailed++; $display("[TB] FAIL div0_latency: got cycle %0d, expected 2", dc); end
    testsRun++; if (res_lo !== 8'hFF || res_hi !== 8'd9) begin testsFailed++; $display("[TB] FAIL div0_res: got %0h/%0d, expected ff/9", res_lo, res_hi); end
    testsRun++; if (div_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL div0_err: got %0b, expected 1", div_err); end
    @(negedge clk);
    testsRun++; if (div_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL div0_err_hold: got %0b, expected 1", div_err); end
  endtask

  task automatic test_div;
    int dc, sc; logic sd; logic [4:0] o1; logic [7:0] x1, y1;
    run_seq(1'b1, 8'd200, 8'd7, dc, sc, sd, o1, x1, y1);
    testsRun++; if (dc !== 17) begin testsFailed++; $display("[TB] FAIL div200_7_latency: got cycle %0d, expected 17", dc); end
    testsRun++; if (res_lo !== 8'd28 || res_hi !== 8'd4) begin testsFailed++; $display("[TB] FAIL div200_7_res: got %0d/%0d, expected 28/4", res_lo, res_hi); end
    testsRun++; if (div_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL div200_7_err: got %0b, expected 0", div_err); end
    testsRun++; if (o1 !== OP_LSL || x1 !== 8'd0 || y1 !== 8'd1) begin testsFailed++; $display("[TB] FAIL div_first_alu: got op %0h a %0d b %0d, expected op 10 a 0 b 1", o1, x1, y1); end
  endtask

  task automatic test_back_to_back;
    int dc, sc; logic sd; logic [4:0] o1; logic [7:0] x1, y1;
    int doneCyc;
    run_seq(1'b0, 8'd3, 8'd3, dc, sc, sd, o1, x1, y1);
    testsRun++; if (res_lo !== 8'd9) begin testsFailed++; $display("[TB] FAIL b2b_mul_res: got %0d, expected 9", res_lo); end
    start = 1'b1; seq_op = 1'b1; opA = 8'd9; opB = 8'd2;
    @(negedge clk);
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_start_in_done: got busy %0b, expected 0", busy); end
    @(negedge clk);
    start = 1'b0;
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_accept_next_idle: got busy %0b, expected 1", busy); end
    doneCyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin doneCyc = c; break; end
      @(negedge clk);
    end
    testsRun++; if (doneCyc !== 17) begin testsFailed++; $display("[TB] FAIL b2b_div_latency: got cycle %0d, expected 17", doneCyc); end
    testsRun++; if (res_lo !== 8'd4 || res_hi !== 8'd1) begin testsFailed++; $display("[TB] FAIL b2b_div_res: got %0d/%0d, expected 4/1", res_lo, res_hi); end
  endtask

  task automatic test_reset_mid;
    logic sawDone;
    core_op = OP_SUB; core_a = 8'd50; core_b = 8'd8;
    @(negedge clk);
    start = 1'b1; seq_op = 1'b0; opA = 8'd13; opB = 8'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; seq_op = 1'b1; opA = 8'd50; opB = 8'd5;
    @(negedge clk);
    start = 1'b0;
    testsRun++; if (busy !== 1'b1 || alu_op !== OP_LSL || alu_a !== 8'd52) begin testsFailed++; $display("[TB] FAIL mid_second_start_ignored: got busy %0b op %0h a %0d, expected 1/10/52", busy, alu_op, alu_a); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    testsRun++; if (busy !== 1'b0 || core_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset_busy: got %0b/%0b, expected 0/0", busy, core_stall); end
    testsRun++; if (res_lo !== 8'd0 || res_hi !== 8'd0 || div_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset_res: got %0d/%0d/%0b, expected 0/0/0", res_lo, res_hi, div_err); end
    testsRun++; if (alu_op !== OP_SUB || alu_a !== 8'd50 || alu_b !== 8'd8) begin testsFailed++; $display("[TB] FAIL mid_reset_bus: got op %0h a %0d b %0d, expected 5/50/8", alu_op, alu_a, alu_b); end
    sawDone = done;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    testsRun++; if (sawDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset_no_done: got activity %0b, expected 0", sawDone); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_mul();
    test_div_zero();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
